// File: rtl/axil_lite_master.sv
// axil_lite_master: single-outstanding AXI4-Lite master.
// A command is latched, issued on AW+W or AR, and its B/R response is held
// on the rsp_* port until consumed.
// Optional watchdog abort: define AXIL_MASTER_TIMEOUT_EN.
module axil_lite_master #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    wr_q;
  logic                    aw_done, w_done;
  logic                    aw_fin, w_fin;
  logic                    abort;

  // AXI request fields come only from the latches, never from cmd_* directly
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_awprot  = PROT;
  assign m_arprot  = PROT;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  // B/R readies are state-only so an early bvalid in WR_REQ is left pending
  assign m_bready  = (state == WR_RESP);
  assign m_rready  = (state == RD_RESP);

  // per-channel completion: already done, or handshaking this cycle
  assign aw_fin = aw_done | (m_awvalid & m_awready);
  assign w_fin  = w_done  | (m_wvalid  & m_wready);

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;

  assign busy  = (state == WR_REQ) || (state == WR_RESP) ||
                 (state == RD_REQ) || (state == RD_RESP);
  // abort on the cycle the count would reach the limit
  assign abort = busy && (wd_cnt == CNT_LAST);

  // watchdog: cleared on accept, counts every busy cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        wd_cnt <= '0;
    else if (cmd_valid && cmd_ready)   wd_cnt <= '0;
    else if (busy)                     wd_cnt <= wd_cnt + CNT_ONE;
  end
`else
  assign abort = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_fin && w_fin) state_n = WR_RESP;
      WR_RESP: if (m_bvalid) state_n = RSP;
      RD_REQ:  if (m_arready) state_n = RD_RESP;
      RD_RESP: if (m_rvalid) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = RSP;
  end

  // command latches, AXI valids, per-channel done flags and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_q      <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else if (abort) begin
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_arvalid <= 1'b0;
      rsp_write <= wr_q;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b11;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q    <= cmd_addr;
          wdata_q   <= cmd_wdata;
          wstrb_q   <= cmd_wstrb;
          wr_q      <= cmd_write;
          m_awvalid <= cmd_write;
          m_wvalid  <= cmd_write;
          m_arvalid <= !cmd_write;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
        end
        WR_REQ: begin
          if (m_awvalid && m_awready) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (m_wvalid && m_wready) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
        end
        WR_RESP: if (m_bvalid) begin
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
          rsp_resp  <= m_bresp;
        end
        RD_REQ: if (m_arready) m_arvalid <= 1'b0;
        RD_RESP: if (m_rvalid) begin
          rsp_write <= 1'b0;
          rsp_rdata <= m_rdata;
          rsp_resp  <= m_rresp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_lite_master.sv
// tb_axil_lite_master: directed vectors against axil_lite_master.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_axil_lite_master;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int n_cmp = 0;
  int n_err = 0;

  axil_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
  endtask

  // zero-wait write: AW+W at cycle 1, B at cycle 2, rsp at cycle 3
  task automatic wr_basic(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b00;
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    chk("wr_c0_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    chk("wr_c1_awvalid", m_awvalid, 1);
    chk("wr_c1_wvalid", m_wvalid, 1);
    chk("wr_c1_awaddr", m_awaddr, a);
    chk("wr_c1_wdata", m_wdata, d);
    chk("wr_c1_wstrb", m_wstrb, s);
    chk("wr_c1_bready", m_bready, 0);
    chk("wr_c1_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_c2_bready", m_bready, 1);
    chk("wr_c2_awvalid", m_awvalid, 0);
    chk("wr_c2_rsp_valid", rsp_valid, 0);
    tick();
    chk("wr_c3_rsp_valid", rsp_valid, 1);
    chk("wr_c3_rsp_write", rsp_write, 1);
    chk("wr_c3_rsp_resp", rsp_resp, 2'b00);
    chk("wr_c3_rsp_rdata", rsp_rdata, 0);
    chk("wr_c3_bready", m_bready, 0);
    m_bvalid = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("wr_c4_rsp_valid", rsp_valid, 0);
    chk("wr_c4_cmd_ready", cmd_ready, 1);
    m_awready = 0; m_wready = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_awaddr", m_awaddr, 0);
    tick();
    tick();
    rst_n = 1;
    tick();

    // 1: zero-wait write
    wr_basic(32'h04, 32'hDEADBEEF, 4'hF);
    tick();

    // 2: read with arready delayed 3 cycles
    m_rvalid = 1; m_rdata = 32'h0000002A; m_rresp = 2'b00;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    tick();
    cmd_valid = 0; cmd_addr = '0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rd_arvalid_c%0d", i), m_arvalid, 1);
      chk($sformatf("rd_araddr_c%0d", i), m_araddr, 32'h10);
      chk($sformatf("rd_rready_c%0d", i), m_rready, 0);
      if (i == 4) m_arready = 1;
      tick();
    end
    m_arready = 0;
    chk("rd_c5_arvalid", m_arvalid, 0);
    chk("rd_c5_rready", m_rready, 1);
    tick();
    m_rvalid = 0; m_rdata = '0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h2A);
    chk("rd_rsp_resp", rsp_resp, 2'b00);
    chk("rd_rsp_write", rsp_write, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rd_after_cmd_ready", cmd_ready, 1);

    // 3: write, W accepted at cycle 1, AW at cycle 5, bvalid forced high from cycle 2
    m_wready = 1; m_awready = 0; m_bresp = 2'b01;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h12345678; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 0; cmd_wdata = '0;
    chk("sk_c1_wvalid", m_wvalid, 1);
    chk("sk_c1_awvalid", m_awvalid, 1);
    tick();
    m_bvalid = 1;
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("sk_c%0d_wvalid", c), m_wvalid, 0);
      chk($sformatf("sk_c%0d_awvalid", c), m_awvalid, 1);
      chk($sformatf("sk_c%0d_bready", c), m_bready, 0);
      chk($sformatf("sk_c%0d_rsp_valid", c), rsp_valid, 0);
      if (c == 5) m_awready = 1;
      tick();
    end
    m_awready = 0;
    chk("sk_c6_bready", m_bready, 1);
    chk("sk_c6_awvalid", m_awvalid, 0);
    tick();
    chk("sk_c7_rsp_valid", rsp_valid, 1);
    chk("sk_c7_rsp_resp", rsp_resp, 2'b01);
    chk("sk_c7_rsp_write", rsp_write, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sk_no_dup_rsp_%0d", c), rsp_valid, 0);
      chk($sformatf("sk_no_dup_bready_%0d", c), m_bready, 0);
      tick();
    end
    m_bvalid = 0; m_wready = 0; m_bresp = 2'b00;

    // 4: read returning SLVERR, response held 10 cycles
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hA5A5_0001; m_rresp = 2'b10;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    tick();
    cmd_valid = 0;
    chk("bp_c1_arvalid", m_arvalid, 1);
    tick();
    chk("bp_c2_rready", m_rready, 1);
    tick();
    m_rdata = 32'hFFFF_FFFF; m_rresp = 2'b11;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h99;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_rsp_valid_%0d", i), rsp_valid, 1);
      chk($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hA5A5_0001);
      chk($sformatf("bp_resp_%0d", i), rsp_resp, 2'b10);
      chk($sformatf("bp_write_%0d", i), rsp_write, 0);
      chk($sformatf("bp_cmd_ready_%0d", i), cmd_ready, 0);
      chk($sformatf("bp_awvalid_%0d", i), m_awvalid, 0);
      if (i == 9) begin
        cmd_valid = 0;
        rsp_ready = 1;
      end
      tick();
    end
    rsp_ready = 0;
    chk("bp_after_cmd_ready", cmd_ready, 1);
    chk("bp_after_rsp_valid", rsp_valid, 0);
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
    tick();

    // 5: reset while in RD_RESP
    m_arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
    tick();
    cmd_valid = 0;
    chk("rr_c1_arvalid", m_arvalid, 1);
    tick();
    m_arready = 0;
    chk("rr_c2_rready", m_rready, 1);
    #2 rst_n = 0;
    #1;
    chk("rr_async_rready", m_rready, 0);
    chk("rr_async_arvalid", m_arvalid, 0);
    chk("rr_async_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1;
    tick();
    chk("rr_post_cmd_ready", cmd_ready, 1);
    chk("rr_post_rsp_valid", rsp_valid, 0);
    wr_basic(32'h44, 32'hCAFE_F00D, 4'hC);
    tick();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // 6: watchdog abort with AW never accepted
    m_awready = 0; m_wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
    tick();
    cmd_valid = 0;
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("to_c%0d_awvalid", c), m_awvalid, 1);
      chk($sformatf("to_c%0d_rsp_valid", c), rsp_valid, 0);
      tick();
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_resp", rsp_resp, 2'b11);
    chk("to_rsp_write", rsp_write, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_awvalid", m_awvalid, 0);
    chk("to_wvalid", m_wvalid, 0);
    chk("to_bready", m_bready, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0; m_wready = 0;
    chk("to_after_cmd_ready", cmd_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
